// File: rtl/mips_processor_core.sv
// Multicycle 32-bit MIPS core: controller FSM, ALU decode and a datapath
// sharing one memory port for instruction fetch and data access.
module mips_core_datapath #(
  parameter int WIDTH   = 32,
  parameter int REGBITS = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] memdata,
  input  logic             ir_write,
  input  logic             pc_write,
  input  logic             pc_write_cond,
  input  logic             jump,
  input  logic             iord,
  input  logic             mdr_write,
  input  logic             alu_src_a,
  input  logic [1:0]       alu_src_b,
  input  logic             alu_funct,
  input  logic             reg_dst,
  input  logic             mem_to_reg,
  input  logic             regwrite,
  output logic [5:0]       op,
  output logic [WIDTH-1:0] addr,
  output logic [WIDTH-1:0] writedata
);

  logic [WIDTH-1:0]   pcOut, instruct, Ain, Bin;
  logic [WIDTH-1:0]   pc_d, ir_d, a_d, b_d, aluout_q, aluout_d, mdr_q, mdr_d;
  logic [WIDTH-1:0]   wrData, imm_ext, src_a, src_b, alu_result;
  logic [REGBITS-1:0] wrAddr, rs, rt, rd;
  logic [WIDTH-1:0]   rf [2**REGBITS];

  assign op        = instruct[31:26];
  assign rs        = instruct[21 +: REGBITS];
  assign rt        = instruct[16 +: REGBITS];
  assign rd        = instruct[11 +: REGBITS];
  assign imm_ext   = {{(WIDTH-16){instruct[15]}}, instruct[15:0]};
  assign wrAddr    = reg_dst ? rd : rt;
  assign wrData    = mem_to_reg ? mdr_q : aluout_q;
  assign addr      = iord ? aluout_q : pcOut;
  assign writedata = Bin;

  always_comb begin
    src_a = alu_src_a ? Ain : pcOut;
    case (alu_src_b)
      2'd0:    src_b = Bin;
      2'd1:    src_b = WIDTH'(4);
      2'd2:    src_b = imm_ext;
      default: src_b = imm_ext << 2;
    endcase
    alu_result = '0;
    if (!alu_funct) begin
      alu_result = src_a + src_b;
    end else begin
      case (instruct[5:0])
        6'h20:   alu_result = src_a + src_b;
        6'h22:   alu_result = src_a - src_b;
        6'h24:   alu_result = src_a & src_b;
        6'h25:   alu_result = src_a | src_b;
        6'h2A:   alu_result = ($signed(src_a) < $signed(src_b)) ? WIDTH'(1) : '0;
        default: alu_result = '0;
      endcase
    end
  end

  // PC priority: sequential fetch increment, taken branch, then jump.
  always_comb begin
    pc_d = pcOut;
    if (pc_write) begin
      pc_d = alu_result;
    end else if (pc_write_cond && (Ain == Bin)) begin
      pc_d = aluout_q;
    end else if (jump) begin
      pc_d = {pcOut[WIDTH-1:28], instruct[25:0], 2'b00};
    end
    ir_d     = ir_write ? memdata : instruct;
    mdr_d    = mdr_write ? memdata : mdr_q;
    aluout_d = alu_result;
    a_d      = (rs == '0) ? '0 : rf[rs];
    b_d      = (rt == '0) ? '0 : rf[rt];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcOut    <= '0;
      instruct <= '0;
      Ain      <= '0;
      Bin      <= '0;
      aluout_q <= '0;
      mdr_q    <= '0;
    end else begin
      pcOut    <= pc_d;
      instruct <= ir_d;
      Ain      <= a_d;
      Bin      <= b_d;
      aluout_q <= aluout_d;
      mdr_q    <= mdr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (regwrite && (wrAddr != '0)) begin
      rf[wrAddr] <= wrData;
    end
  end

endmodule

module mips_processor_core #(
  parameter int WIDTH   = 32,
  parameter int REGBITS = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] memdata,
  output logic [WIDTH-1:0] addr,
  output logic             memread,
  output logic             memwrite,
  output logic [WIDTH-1:0] writedata
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    RTYPEEX, RTYPEWB, BEQEX, ADDIEX, ADDIWB, JEX
  } state_t;

  state_t     state_q, state_d;
  logic [5:0] op;
  logic       ir_write, pc_write, pc_write_cond, jump, iord, mdr_write;
  logic       alu_src_a, alu_funct, reg_dst, mem_to_reg, regwrite;
  logic [1:0] alu_src_b;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:   state_d = DECODE;
      DECODE: begin
        case (op)
          6'h23, 6'h2B: state_d = MEMADR;
          6'h00:        state_d = RTYPEEX;
          6'h04:        state_d = BEQEX;
          6'h08:        state_d = ADDIEX;
          6'h02:        state_d = JEX;
          default:      state_d = FETCH;
        endcase
      end
      MEMADR:  state_d = (op == 6'h23) ? MEMRD : MEMWR;
      MEMRD:   state_d = MEMWB;
      RTYPEEX: state_d = RTYPEWB;
      ADDIEX:  state_d = ADDIWB;
      default: state_d = FETCH;
    endcase
  end

  // Default ALU setup is PC+4 so FETCH needs only the write enables.
  always_comb begin
    memread       = 1'b0;
    memwrite      = 1'b0;
    regwrite      = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    jump          = 1'b0;
    iord          = 1'b0;
    mdr_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'd1;
    alu_funct     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    case (state_q)
      FETCH: begin
        memread  = 1'b1;
        ir_write = 1'b1;
        pc_write = 1'b1;
      end
      DECODE:  alu_src_b = 2'd3;
      MEMADR, ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
      end
      MEMRD: begin
        memread   = 1'b1;
        iord      = 1'b1;
        mdr_write = 1'b1;
      end
      MEMWB: begin
        regwrite   = 1'b1;
        mem_to_reg = 1'b1;
      end
      MEMWR: begin
        memwrite = 1'b1;
        iord     = 1'b1;
      end
      RTYPEEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd0;
        alu_funct = 1'b1;
      end
      RTYPEWB: begin
        regwrite = 1'b1;
        reg_dst  = 1'b1;
      end
      BEQEX:   pc_write_cond = 1'b1;
      ADDIWB:  regwrite = 1'b1;
      JEX:     jump = 1'b1;
      default: ;
    endcase
  end

  mips_core_datapath #(.WIDTH(WIDTH), .REGBITS(REGBITS)) datapath (
    .clk           (clk),
    .reset         (reset),
    .memdata       (memdata),
    .ir_write      (ir_write),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .jump          (jump),
    .iord          (iord),
    .mdr_write     (mdr_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_funct     (alu_funct),
    .reg_dst       (reg_dst),
    .mem_to_reg    (mem_to_reg),
    .regwrite      (regwrite),
    .op            (op),
    .addr          (addr),
    .writedata     (writedata)
  );

endmodule

// File: tb/tb_mips_processor_core.sv
// Self-checking bench for mips_processor_core: runs a short program from a
// word-addressed memory model and scoreboards every register and memory write.
module tb_mips_processor_core;

  typedef struct packed {
    logic        is_mem;
    logic [31:0] where;
    logic [31:0] data;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [31:0] memdata;
  logic [31:0] addr;
  logic        memread;
  logic        memwrite;
  logic [31:0] writedata;

  logic [31:0] mem [256];
  exp_t        sb[$];
  exp_t        exp_e;
  exp_t        got;
  int          checks = 0;
  int          errors = 0;

  mips_processor_core dut (
    .clk       (clk),
    .reset     (reset),
    .memdata   (memdata),
    .addr      (addr),
    .memread   (memread),
    .memwrite  (memwrite),
    .writedata (writedata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign memdata = mem[addr[9:2]];

  always @(posedge clk) begin
    if (memwrite) mem[addr[9:2]] <= writedata;
  end

  // Every write the core makes must match the next queued expectation.
  always @(negedge clk) begin
    if (!reset && (dut.regwrite || memwrite)) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("[TB] FAIL sb_unexpected: got regwrite=%0b memwrite=%0b addr=%h, required no write",
                 dut.regwrite, memwrite, addr);
      end else begin
        exp_e      = sb.pop_front();
        got.is_mem = memwrite;
        got.where  = memwrite ? addr : {27'b0, dut.datapath.wrAddr};
        got.data   = memwrite ? writedata : dut.datapath.wrData;
        if (got !== exp_e) begin
          errors++;
          $display("[TB] FAIL sb_write: got mem=%0b where=%h data=%h, required mem=%0b where=%h data=%h",
                   got.is_mem, got.where, got.data, exp_e.is_mem, exp_e.where, exp_e.data);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[0]  = 32'h20020005;
    mem[1]  = 32'h2003000C;
    mem[2]  = 32'h00432020;
    mem[3]  = 32'hAC040050;
    mem[4]  = 32'h10420002;
    mem[5]  = 32'h200B0063;
    mem[6]  = 32'h200B0063;
    mem[7]  = 32'h8C050050;
    mem[8]  = 32'h10430005;
    mem[9]  = 32'h0062302A;
    mem[10] = 32'h08000010;
    mem[16] = 32'h00623822;
    mem[17] = 32'h00434024;
    mem[18] = 32'h00434825;
    mem[19] = 32'h08000018;
    mem[24] = 32'h20000007;
    mem[25] = 32'h00026020;
    mem[26] = 32'h204AFFFA;
    mem[27] = 32'hAC040058;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (addr !== 32'h0) begin errors++; $display("[TB] FAIL reset_addr: got %h required 0", addr); end
    checks++;
    if (dut.datapath.pcOut !== 32'h0) begin errors++; $display("[TB] FAIL reset_pc: got %h required 0", dut.datapath.pcOut); end
    checks++;
    if (memread !== 1'b1) begin errors++; $display("[TB] FAIL reset_memread: got %b required 1", memread); end
    checks++;
    if (memwrite !== 1'b0) begin errors++; $display("[TB] FAIL reset_memwrite: got %b required 0", memwrite); end
    checks++;
    if (dut.regwrite !== 1'b0) begin errors++; $display("[TB] FAIL reset_regwrite: got %b required 0", dut.regwrite); end
    reset = 1'b0;
  endtask

  task automatic test_addi();
    sb.push_back('{1'b0, 32'd2, 32'd5});
    step(1);
    checks++;
    if (dut.datapath.pcOut !== 32'h4) begin errors++; $display("[TB] FAIL addi_pc: got %h required 4", dut.datapath.pcOut); end
    checks++;
    if (dut.datapath.instruct !== 32'h20020005) begin errors++; $display("[TB] FAIL addi_ir: got %h required 20020005", dut.datapath.instruct); end
    step(2);
    checks++;
    if (dut.datapath.wrData !== 32'h5) begin errors++; $display("[TB] FAIL addi_wrdata: got %h required 5", dut.datapath.wrData); end
    step(1);
  endtask

  task automatic test_rtype();
    sb.push_back('{1'b0, 32'd3, 32'd12});
    step(4);
    sb.push_back('{1'b0, 32'd4, 32'h11});
    step(2);
    checks++;
    if (dut.datapath.Ain !== 32'h5) begin errors++; $display("[TB] FAIL add_ain: got %h required 5", dut.datapath.Ain); end
    checks++;
    if (dut.datapath.Bin !== 32'hC) begin errors++; $display("[TB] FAIL add_bin: got %h required c", dut.datapath.Bin); end
    step(2);
  endtask

  task automatic test_store();
    sb.push_back('{1'b1, 32'h50, 32'h11});
    step(3);
    checks++;
    if (addr !== 32'h50) begin errors++; $display("[TB] FAIL sw_addr: got %h required 50", addr); end
    checks++;
    if (memwrite !== 1'b1) begin errors++; $display("[TB] FAIL sw_memwrite: got %b required 1", memwrite); end
    checks++;
    if (memread !== 1'b0) begin errors++; $display("[TB] FAIL sw_memread: got %b required 0", memread); end
    step(1);
    checks++;
    if (mem[20] !== 32'h11) begin errors++; $display("[TB] FAIL sw_stored: got %h required 11", mem[20]); end
  endtask

  task automatic test_branch_taken();
    step(3);
    checks++;
    if (addr !== 32'h1C) begin errors++; $display("[TB] FAIL beq_taken_addr: got %h required 1c", addr); end
  endtask

  task automatic test_load();
    sb.push_back('{1'b0, 32'd5, 32'h11});
    step(5);
  endtask

  task automatic test_branch_not_taken();
    step(3);
    checks++;
    if (dut.datapath.pcOut !== 32'h24) begin errors++; $display("[TB] FAIL beq_not_taken_pc: got %h required 24", dut.datapath.pcOut); end
  endtask

  task automatic test_slt();
    sb.push_back('{1'b0, 32'd6, 32'd0});
    step(4);
  endtask

  task automatic test_jump();
    step(3);
    checks++;
    if (addr !== 32'h40) begin errors++; $display("[TB] FAIL j_addr: got %h required 40", addr); end
  endtask

  task automatic test_alu_ops();
    sb.push_back('{1'b0, 32'd7, 32'd7});
    sb.push_back('{1'b0, 32'd8, 32'd4});
    sb.push_back('{1'b0, 32'd9, 32'd13});
    step(12);
    step(3);
    checks++;
    if (addr !== 32'h60) begin errors++; $display("[TB] FAIL j2_addr: got %h required 60", addr); end
  endtask

  task automatic test_zero_reg();
    sb.push_back('{1'b0, 32'd0, 32'd7});
    step(4);
    sb.push_back('{1'b0, 32'd12, 32'd5});
    step(2);
    checks++;
    if (dut.datapath.Ain !== 32'h0) begin errors++; $display("[TB] FAIL r0_read: got %h required 0", dut.datapath.Ain); end
    step(2);
    sb.push_back('{1'b0, 32'd10, 32'hFFFFFFFF});
    step(4);
  endtask

  task automatic test_reset_abort();
    step(2);
    reset = 1'b1;
    #1;
    checks++;
    if (addr !== 32'h0) begin errors++; $display("[TB] FAIL abort_addr: got %h required 0", addr); end
    checks++;
    if (memwrite !== 1'b0) begin errors++; $display("[TB] FAIL abort_memwrite: got %b required 0", memwrite); end
    step(1);
    checks++;
    if (mem[22] !== 32'h0) begin errors++; $display("[TB] FAIL abort_nostore: got %h required 0", mem[22]); end
    reset = 1'b0;
    step(1);
    checks++;
    if (dut.datapath.pcOut !== 32'h4) begin errors++; $display("[TB] FAIL abort_refetch_pc: got %h required 4", dut.datapath.pcOut); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_rtype();
    test_store();
    test_branch_taken();
    test_load();
    test_branch_not_taken();
    test_slt();
    test_jump();
    test_alu_ops();
    test_zero_reg();
    test_reset_abort();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL sb_drained: got %0d pending writes required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
